linebuffer_multi: RTL and testbench

- Parametrised successor to the two-RAM ping-pong line buffer.
- Stores NUM_LINES-1 previous video lines in rotating single-port RAMs. Each accepted pixel produces a vertical column of NUM_LINES vertically aligned pixels for 2-D window filters (3x3, 5x5).
- Active line length is runtime-programmable per line, with frame restart via sof.
- Sits between the pixel source and the window/convolution stage.

---
 rtl/linebuffer_multi.sv | 137 +++++++++++++
 tb/tb_linebuffer_multi.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/linebuffer_multi.sv
// Multi-line video line buffer: keeps NUM_LINES-1 previous lines in rotating
// read-first RAMs and emits a vertical column of NUM_LINES pixels per accepted pixel.
module linebuffer_multi #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_LENGTH = 1920,
  parameter int NUM_LINES  = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [ADDR_WIDTH-1:0]           line_length,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            in_valid,
  input  logic                            sof,
  output logic [NUM_LINES*DATA_WIDTH-1:0] data_out,
  output logic                            out_valid,
  output logic                            out_eol
);

  localparam int NUM_RAMS = NUM_LINES - 1;
  localparam int SEL_W    = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1;
  localparam int ROW_W    = $clog2(NUM_LINES);

  localparam logic [ADDR_WIDTH-1:0] MAX_LEN  = ADDR_WIDTH'(MAX_LENGTH);
  localparam logic [ROW_W-1:0]      ROW_FULL = ROW_W'(NUM_LINES - 1);
  localparam logic [SEL_W-1:0]      SEL_LAST = SEL_W'(NUM_RAMS - 1);

  logic [ADDR_WIDTH-1:0] col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
  logic [SEL_W-1:0]      wr_sel_q, wr_sel_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [DATA_WIDTH-1:0] pix_q;
  logic [SEL_W-1:0]      tap_sel_q;
  logic                  out_valid_q;
  logic                  out_eol_q;

  // Effective counters for the pixel being accepted (sof overrides the running state).
  logic [ADDR_WIDTH-1:0] line_len_clamped;
  logic [ADDR_WIDTH-1:0] acc_col;
  logic [ROW_W-1:0]      acc_row;
  logic [SEL_W-1:0]      acc_sel;
  logic [ADDR_WIDTH-1:0] acc_len;
  logic                  acc_eol;
  logic                  acc_emit;

  logic [NUM_RAMS*DATA_WIDTH-1:0] rd_flat;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    wr_sel_d  = wr_sel_q;
    len_d     = len_q;

    line_len_clamped = (line_length <= ADDR_WIDTH'(1) || line_length > MAX_LEN)
                       ? MAX_LEN : line_length;
    acc_col  = sof ? '0 : col_cnt_q;
    acc_row  = sof ? '0 : row_cnt_q;
    acc_sel  = sof ? '0 : wr_sel_q;
    acc_len  = (sof || col_cnt_q == '0) ? line_len_clamped : len_q;
    acc_eol  = (acc_col == acc_len - 1'b1);
    acc_emit = !sof && (acc_row == ROW_FULL);

    if (in_valid) begin
      len_d = acc_len;
      if (acc_eol) begin
        col_cnt_d = '0;
        wr_sel_d  = (acc_sel == SEL_LAST) ? '0 : acc_sel + 1'b1;
        row_cnt_d = (acc_row == ROW_FULL) ? acc_row : acc_row + 1'b1;
      end else begin
        col_cnt_d = acc_col + 1'b1;
        row_cnt_d = acc_row;
        wr_sel_d  = acc_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_n) begin
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      wr_sel_q    <= '0;
      len_q       <= MAX_LEN;
      pix_q       <= '0;
      tap_sel_q   <= '0;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      wr_sel_q    <= wr_sel_d;
      len_q       <= len_d;
      out_valid_q <= in_valid && acc_emit;
      out_eol_q   <= in_valid && acc_emit && acc_eol;
      if (in_valid) begin
        pix_q     <= data_in;
        tap_sel_q <= acc_sel;
      end
    end
  end

  for (genvar r = 0; r < NUM_RAMS; r++) begin : g_ram
    logic [DATA_WIDTH-1:0] mem [MAX_LENGTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // NOTE: RAM arrays get no reset; row_cnt masks stale contents and a reset would prevent RAM inference.
    always_ff @(posedge clk) begin
      if (in_valid && acc_sel == SEL_W'(r)) mem[acc_col] <= data_in;
    end

    // Read in the same edge as the write returns the old word (read-first).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        rd_q <= '0;
      else if (in_valid) rd_q <= mem[acc_col];
    end

    assign rd_flat[r*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

  int tap_idx;

  // Slice k comes from the RAM written k lines ago; RAM[wr_sel] holds the oldest line.
  always_comb begin
    tap_idx  = 0;
    data_out = '0;
    data_out[DATA_WIDTH-1:0] = pix_q;
    for (int k = 1; k < NUM_LINES; k++) begin
      tap_idx = (int'(tap_sel_q) + NUM_LINES - 1 - k) % NUM_RAMS;
      data_out[k*DATA_WIDTH +: DATA_WIDTH] = rd_flat[tap_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign out_valid = out_valid_q;
  assign out_eol   = out_eol_q;

endmodule

// File: tb/tb_linebuffer_multi.sv
// Scoreboard bench for linebuffer_multi (NUM_LINES=3, 16-bit pixels, 1920 max length).
module tb_linebuffer_multi;

  localparam int DW = 16;
  localparam int AW = 11;
  localparam int NL = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     line_length;
  logic [DW-1:0]     data_in;
  logic              in_valid;
  logic              sof;
  logic [NL*DW-1:0]  data_out;
  logic              out_valid;
  logic              out_eol;

  linebuffer_multi #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LENGTH(1920), .NUM_LINES(NL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .line_length(line_length), .data_in(data_in),
    .in_valid(in_valid), .sof(sof), .data_out(data_out), .out_valid(out_valid),
    .out_eol(out_eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL*DW-1:0] data;
    logic             eol;
    logic             dc;
  } exp_t;

  exp_t             sb[$];
  int               checks   = 0;
  int               failures = 0;
  int               row_len[16];
  logic             hold_en  = 1'b0;
  logic [NL*DW-1:0] last_exp = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int base, input int r, input int c);
    return DW'(base + 16 * r + c);
  endfunction

  // Monitor: compares every presented column with the head of the scoreboard.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(out_valid), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (!e.dc) begin
          check("column", 64'(data_out), 64'(e.data));
          last_exp = e.data;
        end
        check("eol", 64'(out_eol), 64'(e.eol));
      end
    end else if (hold_en) begin
      check("hold", 64'(data_out), 64'(last_exp));
    end
  end

  // Drive ncols pixels of frame row r; ll is presented on column 0, ll_mid afterwards.
  task automatic send_line(input int r, input int ncols, input int ll, input int ll_mid,
                           input int exp_len, input int base, input bit sof0, input int gap);
    exp_t e;
    row_len[r] = ncols;
    for (int c = 0; c < ncols; c++) begin
      @(negedge clk);
      line_length = AW'((c == 0) ? ll : ll_mid);
      data_in     = pix(base, r, c);
      in_valid    = 1'b1;
      sof         = sof0 && (c == 0);
      if (r >= 2) begin
        e.data = {pix(base, r - 2, c), pix(base, r - 1, c), pix(base, r, c)};
        e.eol  = (c == exp_len - 1);
        e.dc   = (c >= row_len[r-1]) || (c >= row_len[r-2]);
        sb.push_back(e);
      end
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        in_valid = 1'b0;
        sof      = 1'b0;
        hold_en  = 1'b1;
      end
    end
    hold_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      sof      = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check(name, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sof = 1'b0; data_in = '0; line_length = AW'(4);
    repeat (3) @(negedge clk);
    check("reset_valid", 64'(out_valid), 64'(0));
    check("reset_eol",   64'(out_eol),   64'(0));
    check("reset_data",  64'(data_out),  64'(0));
    rst_n = 1'b1;
    idle(2);

    // Basic columns and rotation: rows 0..4, length 4, continuous.
    for (int r = 0; r < 5; r++) send_line(r, 4, 4, 4, 4, 0, r == 0, 0);
    idle(2);
    drain("drain_basic");

    // Gaps: row 2 with three idle cycles after each pixel.
    send_line(0, 4, 4, 4, 4, 0, 1'b1, 0);
    send_line(1, 4, 4, 4, 4, 0, 1'b0, 0);
    send_line(2, 4, 4, 4, 4, 0, 1'b0, 3);
    idle(2);
    drain("drain_gaps");

    // Mid-frame restart at (3,2): old frame is discarded, new frame fills again.
    for (int r = 0; r < 3; r++) send_line(r, 4, 4, 4, 4, 'h200, r == 0, 0);
    send_line(3, 2, 4, 4, 4, 'h200, 1'b0, 0);
    for (int r = 0; r < 3; r++) send_line(r, 4, 4, 4, 4, 'h300, r == 0, 0);
    idle(2);
    drain("drain_restart");

    // Runtime length: 4,4,4, then 6 (wrong value mid-line), then 0 and 4000 clamp to 1920.
    for (int r = 0; r < 3; r++) send_line(r, 4, 4, 4, 4, 'h400, r == 0, 0);
    send_line(3, 6, 6, 3, 6, 'h400, 1'b0, 0);
    send_line(4, 1920, 0, 5, 1920, 'h400, 1'b0, 0);
    send_line(5, 1920, 4000, 7, 1920, 'h400, 1'b0, 0);
    idle(2);
    drain("drain_length");

    // Async reset mid-row 3, asserted between clock edges.
    for (int r = 0; r < 3; r++) send_line(r, 4, 4, 4, 4, 'h500, r == 0, 0);
    send_line(3, 2, 4, 4, 4, 'h500, 1'b0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_reset_valid", 64'(out_valid), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(out_valid), 64'(0));
    check("async_reset_data",  64'(data_out),  64'(0));
    check("async_reset_eol",   64'(out_eol),   64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 3; r++) send_line(r, 4, 4, 4, 4, 'h600, r == 0, 0);
    idle(2);
    drain("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
